// File: rtl/display_scan_decoder.sv
// display_scan_decoder
// Receive side of a multiplexed 7-segment drive. It samples the active-low
// anode/segment bus and rebuilds the four displayed digits (MM:SS) as BCD.
// The decoder checks the scan order and rejects unknown segment patterns.
// A digit is committed only after it repeats for STABLE_FRAMES frames.
// Optional build macro: SCAN_DECODER_HOLD_EN. When it is defined, a committed
// blank sets blank_mask but leaves the digit output at its last numeric value.
module display_scan_decoder #(
    parameter int STABLE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_en,
    input  logic [3:0] anode,
    input  logic [6:0] segments,
    output logic [3:0] seconds_units,
    output logic [3:0] seconds_tens,
    output logic [3:0] minutes_units,
    output logic [3:0] minutes_tens,
    output logic [3:0] blank_mask,
    output logic       frame_valid,
    output logic       seq_error,
    output logic       seg_error,
    output logic       locked
);

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_FRAMES);
    localparam logic [3:0] CAND_INVALID = 4'hE;
    localparam logic [3:0] DIGIT_BLANK  = 4'hF;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_TRACK    = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       expect_q, expect_d;
    logic [3:0][3:0]  digit_q, digit_d;
    logic [3:0]       blank_q, blank_d;
    logic [3:0][3:0]  cand_q, cand_d;
    logic [3:0][3:0]  cnt_q, cnt_d;
    logic             frame_q, frame_d;
    logic             seq_err_q, seq_err_d;
    logic             seg_err_q, seg_err_d;
    logic             locked_q, locked_d;

    logic             anode_ok;
    logic             anode_idle;
    logic [1:0]       anode_idx;
    logic             seg_ok;
    logic [3:0]       seg_val;
    logic             process;
    logic [3:0]       new_cnt;

    // Anode decode: one-hot-low select to digit index; all-high is idle
    always_comb begin
        anode_ok   = 1'b1;
        anode_idle = 1'b0;
        anode_idx  = 2'd0;
        case (anode)
            4'b1110: anode_idx = 2'd0;
            4'b1101: anode_idx = 2'd1;
            4'b1011: anode_idx = 2'd2;
            4'b0111: anode_idx = 2'd3;
            4'b1111: begin
                anode_ok   = 1'b0;
                anode_idle = 1'b1;
            end
            default: anode_ok = 1'b0;
        endcase
    end

    // Segment decode: active-low gfedcba pattern to BCD, all-off is blank
    always_comb begin
        seg_ok  = 1'b1;
        seg_val = CAND_INVALID;
        case (segments)
            7'b1000000: seg_val = 4'd0;
            7'b1111001: seg_val = 4'd1;
            7'b0100100: seg_val = 4'd2;
            7'b0110000: seg_val = 4'd3;
            7'b0011001: seg_val = 4'd4;
            7'b0010010: seg_val = 4'd5;
            7'b0000010: seg_val = 4'd6;
            7'b1111000: seg_val = 4'd7;
            7'b0000000: seg_val = 4'd8;
            7'b0010000: seg_val = 4'd9;
            7'b1111111: seg_val = DIGIT_BLANK;
            default:    seg_ok  = 1'b0;
        endcase
    end

    // Next state: scan tracking, per-digit stability filter and commit
    always_comb begin
        state_d   = state_q;
        expect_d  = expect_q;
        digit_d   = digit_q;
        blank_d   = blank_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        locked_d  = locked_q;
        frame_d   = 1'b0;
        seq_err_d = 1'b0;
        seg_err_d = 1'b0;
        process   = 1'b0;
        new_cnt   = 4'd0;

        if (sample_en && !anode_idle) begin
            case (state_q)
                ST_UNLOCKED: begin
                    // Only the rightmost digit can start a lock
                    if (anode_ok && anode_idx == 2'd0) begin
                        process  = 1'b1;
                        state_d  = ST_TRACK;
                        expect_d = 2'd1;
                    end
                end
                ST_TRACK: begin
                    if (anode_ok && anode_idx == expect_q) begin
                        process  = 1'b1;
                        expect_d = expect_q + 2'd1;
                    end else if (anode_ok && anode_idx == (expect_q - 2'd1)) begin
                        // Same digit sampled again within its scan slot
                        process = 1'b0;
                    end else begin
                        // Partial frame is dropped; committed digits stay put
                        seq_err_d = 1'b1;
                        state_d   = ST_UNLOCKED;
                        locked_d  = 1'b0;
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end

        if (process) begin
            if (!seg_ok) begin
                seg_err_d            = 1'b1;
                cand_d[anode_idx]    = CAND_INVALID;
                cnt_d[anode_idx]     = 4'd0;
            end else begin
                if (seg_val == cand_q[anode_idx]) begin
                    new_cnt = (cnt_q[anode_idx] == 4'hF) ? 4'hF : cnt_q[anode_idx] + 4'd1;
                end else begin
                    cand_d[anode_idx] = seg_val;
                    new_cnt           = 4'd1;
                end
                cnt_d[anode_idx] = new_cnt;
                if (new_cnt >= STABLE_CNT) begin
                    blank_d[anode_idx] = (seg_val == DIGIT_BLANK);
`ifdef SCAN_DECODER_HOLD_EN
                    // Blinking blanks leave the last numeric value readable
                    if (seg_val != DIGIT_BLANK) begin
                        digit_d[anode_idx] = seg_val;
                    end
`else
                    digit_d[anode_idx] = seg_val;
`endif
                end
            end
            // Reaching idx3 in TRACK implies idx0..idx2 came in order
            if (anode_idx == 2'd3) begin
                frame_d  = 1'b1;
                locked_d = 1'b1;
            end
        end
    end

    // State and registered outputs; reset discards any partial frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_UNLOCKED;
            expect_q  <= 2'd0;
            digit_q   <= {4{DIGIT_BLANK}};
            blank_q   <= 4'b1111;
            cand_q    <= {4{CAND_INVALID}};
            cnt_q     <= '0;
            frame_q   <= 1'b0;
            seq_err_q <= 1'b0;
            seg_err_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            expect_q  <= expect_d;
            digit_q   <= digit_d;
            blank_q   <= blank_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            seq_err_q <= seq_err_d;
            seg_err_q <= seg_err_d;
            locked_q  <= locked_d;
        end
    end

    assign seconds_units = digit_q[0];
    assign seconds_tens  = digit_q[1];
    assign minutes_units = digit_q[2];
    assign minutes_tens  = digit_q[3];
    assign blank_mask    = blank_q;
    assign frame_valid   = frame_q;
    assign seq_error     = seq_err_q;
    assign seg_error     = seg_err_q;
    assign locked        = locked_q;

endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder with a reference model and a
// per-cycle output compare, plus literal expectations at key points.
module tb_display_scan_decoder;

    localparam int ST = 2;

    localparam logic [3:0] A0 = 4'b1110, A1 = 4'b1101, A2 = 4'b1011, A3 = 4'b0111;
    localparam logic [3:0] AIDLE = 4'b1111;
    localparam logic [6:0] P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001, P5 = 7'b0010010, P7 = 7'b1111000;
    localparam logic [6:0] PB = 7'b1111111, PBAD = 7'b0101010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_en = 1'b0;
    logic [3:0] anode = AIDLE;
    logic [6:0] segments = PB;
    logic [3:0] seconds_units, seconds_tens, minutes_units, minutes_tens, blank_mask;
    logic       frame_valid, seq_error, seg_error, locked;

    display_scan_decoder #(.STABLE_FRAMES(ST)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .anode(anode),
        .segments(segments), .seconds_units(seconds_units),
        .seconds_tens(seconds_tens), .minutes_units(minutes_units),
        .minutes_tens(minutes_tens), .blank_mask(blank_mask),
        .frame_valid(frame_valid), .seq_error(seq_error),
        .seg_error(seg_error), .locked(locked)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state: last processed digit index (-1 = not locked)
    int         m_last;
    logic [3:0] m_digit [4];
    logic [3:0] m_blank;
    int         m_cand [4];
    int         m_cnt [4];
    logic       m_fv, m_seq, m_seg, m_locked;

    logic [6:0] pat_tab [11] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b1111111};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int seg_lookup(input logic [6:0] s);
        for (int k = 0; k < 11; k++) begin
            if (pat_tab[k] == s) return (k == 10) ? 15 : k;
        end
        return -1;
    endfunction

    function automatic int anode_lookup(input logic [3:0] a);
        for (int k = 0; k < 4; k++) begin
            if (a == ~(4'b0001 << k)) return k;
        end
        return (a == AIDLE) ? -2 : -1;
    endfunction

    task automatic model_reset();
        m_last = -1;
        for (int i = 0; i < 4; i++) begin
            m_digit[i] = 4'hF;
            m_cand[i]  = 14;
            m_cnt[i]   = 0;
        end
        m_blank = 4'b1111;
        m_fv = 0; m_seq = 0; m_seg = 0; m_locked = 0;
    endtask

    task automatic model_step(input logic en, input logic [3:0] an, input logic [6:0] sg);
        int k, v;
        m_fv = 0; m_seq = 0; m_seg = 0;
        if (!en) return;
        k = anode_lookup(an);
        if (k == -2) return;
        if (m_last < 0) begin
            if (k != 0) return;
        end else if (k == m_last) begin
            return;
        end else if (k != (m_last + 1) % 4) begin
            m_seq = 1; m_locked = 0; m_last = -1;
            return;
        end
        m_last = k;
        v = seg_lookup(sg);
        if (v < 0) begin
            m_seg = 1; m_cand[k] = 14; m_cnt[k] = 0;
        end else begin
            if (v == m_cand[k]) m_cnt[k] = (m_cnt[k] >= 15) ? 15 : m_cnt[k] + 1;
            else begin m_cand[k] = v; m_cnt[k] = 1; end
            if (m_cnt[k] >= ST) begin
                m_blank[k] = (v == 15);
`ifdef SCAN_DECODER_HOLD_EN
                if (v != 15) m_digit[k] = 4'(v);
`else
                m_digit[k] = 4'(v);
`endif
            end
        end
        if (k == 3) begin m_fv = 1; m_locked = 1; end
    endtask

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("seconds_units", seconds_units, m_digit[0]);
            chk("seconds_tens",  seconds_tens,  m_digit[1]);
            chk("minutes_units", minutes_units, m_digit[2]);
            chk("minutes_tens",  minutes_tens,  m_digit[3]);
            chk("blank_mask",    blank_mask,    m_blank);
            chk("frame_valid",   frame_valid,   m_fv);
            chk("seq_error",     seq_error,     m_seq);
            chk("seg_error",     seg_error,     m_seg);
            chk("locked",        locked,        m_locked);
        end
    end

    task automatic sample(input logic en, input logic [3:0] an, input logic [6:0] sg);
        @(negedge clk);
        sample_en = en; anode = an; segments = sg;
        @(posedge clk);
        model_step(en, an, sg);
        #1;
        $display("[TB] t=%0t en=%0b anode=%b seg=%b -> %0h%0h:%0h%0h blank=%b fv=%0b seqe=%0b sege=%0b lock=%0b",
                 $time, en, an, sg, minutes_tens, minutes_units, seconds_tens, seconds_units,
                 blank_mask, frame_valid, seq_error, seg_error, locked);
    endtask

    task automatic frame(input logic [6:0] d0, input logic [6:0] d1,
                         input logic [6:0] d2, input logic [6:0] d3);
        sample(1'b1, A0, d0);
        sample(1'b1, A1, d1);
        sample(1'b1, A2, d2);
        sample(1'b1, A3, d3);
    endtask

    initial begin
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_digits", {minutes_tens, minutes_units, seconds_tens, seconds_units}, 16'hFFFF);
        chk("reset_blank", blank_mask, 4'b1111);
        chk("reset_pulses", {frame_valid, seq_error, seg_error, locked}, 4'b0000);
        reset = 1'b0;

        // Two frames of 5,4,3,2: commit on the 8th sample
        frame(P5, P4, P3, P2);
        chk("first_frame_valid", frame_valid, 1'b1);
        chk("first_frame_locked", locked, 1'b1);
        sample(1'b1, A0, P5);
        sample(1'b1, A1, P4);
        sample(1'b1, A2, P3);
        chk("tens_before_8th", minutes_tens, 4'hF);
        sample(1'b1, A3, P2);
        chk("digits_5432", {minutes_tens, minutes_units, seconds_tens, seconds_units}, 16'h2345);
        chk("blank_after_commit", blank_mask, 4'b0000);

        // Out-of-order jump 1110 -> 1011
        sample(1'b1, A0, P5);
        sample(1'b1, A2, P3);
        chk("jump_seq_error", seq_error, 1'b1);
        chk("jump_unlocked", locked, 1'b0);
        chk("jump_hold", {minutes_tens, minutes_units, seconds_tens, seconds_units}, 16'h2345);
        frame(P5, P4, P3, P2);
        chk("resume_frame_valid", frame_valid, 1'b1);

        // Unknown pattern on idx2
        sample(1'b1, A0, P5);
        sample(1'b1, A1, P4);
        sample(1'b1, A2, PBAD);
        chk("bad_seg_error", seg_error, 1'b1);
        chk("bad_seg_hold", minutes_units, 4'd3);
        sample(1'b1, A3, P2);
        chk("bad_seg_frame_valid", frame_valid, 1'b1);

        // Commit 7 on digits 2,3, alternate blank/7, then hold blank
        frame(P5, P4, P7, P7);
        frame(P5, P4, P7, P7);
        chk("digits_77", {minutes_tens, minutes_units}, 8'h77);
        for (int r = 0; r < 2; r++) begin
            frame(P5, P4, PB, PB);
            frame(P5, P4, P7, P7);
        end
        chk("alternate_no_blank", blank_mask, 4'b0000);
        frame(P5, P4, PB, PB);
        frame(P5, P4, PB, PB);
        chk("hold_blank_mask", blank_mask, 4'b1100);
`ifdef SCAN_DECODER_HOLD_EN
        chk("hold_blank_digits", {minutes_tens, minutes_units}, 8'h77);
`else
        chk("hold_blank_digits", {minutes_tens, minutes_units}, 8'hFF);
`endif

        // Duplicate, idle and disabled samples inside a frame
        sample(1'b1, A0, P5);
        sample(1'b1, A1, P4);
        sample(1'b1, A1, P4);
        chk("dup_no_error", seq_error, 1'b0);
        sample(1'b1, AIDLE, PB);
        sample(1'b0, 4'b0000, PBAD);
        sample(1'b0, A3, P1);
        chk("disabled_no_error", {seq_error, seg_error}, 2'b00);
        sample(1'b1, A2, PB);
        sample(1'b1, A3, PB);
        chk("dup_frame_valid", frame_valid, 1'b1);

        // Reset while idx2 is expected
        sample(1'b1, A0, P5);
        sample(1'b1, A1, P4);
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("midreset_digits", {minutes_tens, minutes_units, seconds_tens, seconds_units}, 16'hFFFF);
        chk("midreset_blank", blank_mask, 4'b1111);
        chk("midreset_locked", locked, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        sample(1'b1, A1, P4);
        chk("unlocked_ignore", seq_error, 1'b0);
        frame(P1, P2, P3, P4);
        frame(P1, P2, P3, P4);
        chk("digits_4321", {minutes_tens, minutes_units, seconds_tens, seconds_units}, 16'h4321);
        chk("relock", locked, 1'b1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
